one_to_six_dist: RTL and testbench

ONE_TO_SIX_DIST -- requirements
Module: one_to_six_dist

---
 rtl/one_to_six_dist_pkg.sv | 13 +
 rtl/dist_slot.sv | 47 ++++
 rtl/one_to_six_dist.sv | 86 ++++++++
 tb/tb_one_to_six_dist.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/one_to_six_dist_pkg.sv
// Shared widths and channel state encoding for the one-to-six distributor.
package one_to_six_dist_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/dist_slot.sv
// One-entry holding register with valid flag; accepts a new word when empty
// or when the current word is drained in the same cycle.
module dist_slot
    import one_to_six_dist_pkg::*;
#(
    parameter int DATA_W = one_to_six_dist_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              q_ready,
    output logic              ready,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = in_data;
        end else if (state_q == FULL && q_ready) begin
            // data is kept on drain; only the valid flag drops
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign ready   = (state_q == EMPTY) || q_ready;
    assign q_valid = (state_q == FULL);
    assign q_data  = data_q;

endmodule

// File: rtl/one_to_six_dist.sv
// Routes one input word per cycle to one of six holding registers by in_sel.
// Optional DIST_ERR_EN adds a sticky invalid-select flag and a drop counter.
module one_to_six_dist
    import one_to_six_dist_pkg::*;
#(
    parameter int DATA_W = one_to_six_dist_pkg::DATA_W,
    parameter int NUM_CH = one_to_six_dist_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [DATA_W-1:0] q3,
    output logic [DATA_W-1:0] q4,
    output logic [DATA_W-1:0] q5,
    output logic [DATA_W-1:0] q6,
    output logic [NUM_CH-1:0] q_valid,
    input  logic [NUM_CH-1:0] q_ready
`ifdef DIST_ERR_EN
    ,
    output logic              err,
    output logic [7:0]        drop_cnt
`endif
);

    logic [NUM_CH-1:0]        slot_ready;
    logic [NUM_CH-1:0]        slot_load;
    logic [DATA_W-1:0]        slot_data [NUM_CH];
    logic [2**SEL_W-1:0]      ready_ext;

    // unused select codes read as ready so invalid words are swallowed
    assign ready_ext = {{(2**SEL_W-NUM_CH){1'b1}}, slot_ready};
    assign in_ready  = ready_ext[in_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign slot_load[k] = in_valid && in_ready && (in_sel == SEL_W'(k));

        dist_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (slot_load[k]),
            .in_data (in_data),
            .q_ready (q_ready[k]),
            .ready   (slot_ready[k]),
            .q_valid (q_valid[k]),
            .q_data  (slot_data[k])
        );
    end

    assign q1 = slot_data[0];
    assign q2 = slot_data[1];
    assign q3 = slot_data[2];
    assign q4 = slot_data[3];
    assign q5 = slot_data[4];
    assign q6 = slot_data[5];

`ifdef DIST_ERR_EN
    logic       err_q;
    logic [7:0] drop_q;
    logic       drop_xfer;

    assign drop_xfer = in_valid && (in_sel >= SEL_W'(NUM_CH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop_xfer) begin
            err_q <= 1'b1;
            if (drop_q != '1) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_one_to_six_dist.sv
// Self-checking bench for one_to_six_dist: directed vectors plus a randomized
// phase checked every cycle against a pending-word list model.
module tb_one_to_six_dist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] q1, q2, q3, q4, q5, q6;
    logic [5:0]  q_valid;
    logic [5:0]  q_ready;
`ifdef DIST_ERR_EN
    logic        err;
    logic [7:0]  drop_cnt;
`endif

    one_to_six_dist #(
        .DATA_W (32),
        .NUM_CH (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .q4       (q4),
        .q5       (q5),
        .q6       (q6),
        .q_valid  (q_valid),
        .q_ready  (q_ready)
`ifdef DIST_ERR_EN
        ,
        .err      (err),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] qs [6];
    assign qs[0] = q1;
    assign qs[1] = q2;
    assign qs[2] = q3;
    assign qs[3] = q4;
    assign qs[4] = q5;
    assign qs[5] = q6;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of words accepted but not yet delivered, in acceptance order.
    typedef struct {
        int          ch;
        logic [31:0] d;
    } item_t;

    item_t       pend[$];
    logic [31:0] last [6];
    bit          m_err;
    int          m_drop;

    function automatic bit holds(input int ch);
        foreach (pend[i]) if (pend[i].ch == ch) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input logic [2:0] sel, input logic [5:0] qr);
        if (sel >= 3'd6) return 1'b1;
        return !holds(int'(sel)) || qr[sel];
    endfunction

    initial begin
        for (int i = 0; i < 6; i++) last[i] = '0;
        m_err  = 1'b0;
        m_drop = 0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            for (int i = 0; i < 6; i++) last[i] = '0;
            m_err  = 1'b0;
            m_drop = 0;
        end else begin
            bit acc;
            acc = in_valid && m_ready(in_sel, q_ready);
            for (int k = 0; k < 6; k++) begin
                if (q_ready[k]) begin
                    for (int i = 0; i < pend.size(); i++) begin
                        if (pend[i].ch == k) begin
                            pend.delete(i);
                            break;
                        end
                    end
                end
            end
            if (acc && in_sel < 3'd6) begin
                pend.push_back('{ch: int'(in_sel), d: in_data});
                last[in_sel] = in_data;
            end else if (acc) begin
                m_err = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    end

    bit model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            logic [5:0] ev;
            for (int k = 0; k < 6; k++) ev[k] = holds(k);
            check("cyc_in_ready", 64'(in_ready), 64'(m_ready(in_sel, q_ready)));
            check("cyc_q_valid", 64'(q_valid), 64'(ev));
            for (int k = 0; k < 6; k++) begin
                if (ev[k]) begin
                    foreach (pend[i]) if (pend[i].ch == k) begin
                        check("cyc_q_head", 64'(qs[k]), 64'(pend[i].d));
                        break;
                    end
                end
                check("cyc_q_data", 64'(qs[k]), 64'(last[k]));
            end
`ifdef DIST_ERR_EN
            check("cyc_err", 64'(err), 64'(m_err));
            check("cyc_drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_sel   = '0;
        in_valid = 1'b0;
        q_ready  = '0;
        step();
        step();
        model_on = 1'b1;
        check("reset_q_valid", 64'(q_valid), 64'd0);
        check("reset_q3", 64'(q3), 64'd0);

        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 32'hDEADBEEF;
        #1;
        check("first_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("first_q3", 64'(q3), 64'hDEADBEEF);
        check("first_q_valid", 64'(q_valid), 64'b000100);

        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 32'h1;
        #1;
        check("full_blocks", 64'(in_ready), 64'd0);
        q_ready = 6'b000100;
        #1;
        check("full_drain_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("thru_q3", 64'(q3), 64'h1);
        check("thru_q_valid", 64'(q_valid), 64'b000100);
        step();
        q_ready = '0;
        #1;
        check("drain_q_valid", 64'(q_valid), 64'd0);
        check("drain_q3_held", 64'(q3), 64'h1);

        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            in_data  = 32'(i);
            #1;
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("b2b_q_valid", 64'(q_valid), 64'h3F);
        for (int i = 0; i < 6; i++) check("b2b_qk", 64'(qs[i]), 64'(i));

        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_data  = 32'hBAD;
        #1;
        check("inv_in_ready", 64'(in_ready), 64'd1);
        step();
        check("inv_q_valid", 64'(q_valid), 64'h3F);
`ifdef DIST_ERR_EN
        check("inv_err", 64'(err), 64'd1);
        check("inv_drop1", 64'(drop_cnt), 64'd1);
        repeat (299) step();
        check("inv_drop_sat", 64'(drop_cnt), 64'd255);
`endif
        in_valid = 1'b0;
        q_ready  = 6'h3F;
        step();
        q_ready  = '0;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 32'h1111;
        step();
        in_sel   = 3'd4;
        in_data  = 32'h5555;
        step();
        in_valid = 1'b0;
        #1;
        check("pre_rst_q_valid", 64'(q_valid), 64'b010001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_q_valid", 64'(q_valid), 64'd0);
        check("rst_q1", 64'(q1), 64'd0);
        check("rst_q5", 64'(q5), 64'd0);
`ifdef DIST_ERR_EN
        check("rst_err", 64'(err), 64'd0);
`endif

        for (int n = 0; n < 10000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 3'($urandom_range(0, 7));
            in_data  = $urandom;
            q_ready  = 6'($urandom);
            rst_n    = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        q_ready  = 6'h3F;
        step();
        step();
        check("final_empty", 64'(q_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
